uart_vector_player: RTL and testbench

Synthesizable byte-stream sequencer that plays a stored vector of bytes into a UART transmitter via its `tx_req`/`tx_busy` handshake. It replaces fixed simulation-only vector feeders with a reusable block that does the following:
- holds the vector in a writable on-chip buffer;
- supports configurable length, inter-byte gap and looping;
- supports abort and restart.

It sits between a host/control path (or bench) and the `uart` instance feeding a `toplevel_bruteforcer` chain.

---
 rtl/uart_vector_player.sv | 189 ++++++++++++++++++
 tb/tb_uart_vector_player.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_vector_player.sv
// uart_vector_player: plays a stored byte vector into a UART transmitter over the
// tx_req/tx_busy handshake, with programmable length, looping, per-byte gap and abort.
//
// Optional feature macro: UART_PLAYER_CHECKSUM_EN (running mod-256 checksum of sent
// bytes). When undefined, checksum is tied to 8'h00.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  buffer write port (accepted in any state)
//   length, loop_en     playback length and loop mode, sampled on start
//   start, abort        one-cycle start pulse, abort (highest priority)
//   tx_byte, tx_req     byte and one-cycle send request to the UART
//   tx_busy             UART busy, rises the cycle after tx_req
//   active, done        playback in progress, one-cycle normal-completion pulse
//   sent_count          bytes sent in the current pass
//   pass_count          completed passes since start (saturating)
//   checksum            running mod-256 sum of sent bytes
module uart_vector_player #(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned GAP_CYCLES = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   length,
  input  logic          loop_en,
  input  logic          start,
  input  logic          abort,
  output logic [7:0]    tx_byte,
  output logic          tx_req,
  input  logic          tx_busy,
  output logic          active,
  output logic          done,
  output logic [AW:0]   sent_count,
  output logic [15:0]   pass_count,
  output logic [7:0]    checksum
);

  localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GapLast  = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   DepthLen = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StHold, StWaitb, StGap} state_e;

  // State entered after a byte completes and playback continues.
  localparam state_e BeatNext = (GAP_CYCLES == 0) ? StFetch : StGap;

  state_e          state_q, state_d;
  logic [AW:0]     addr_q, addr_d;
  logic [AW:0]     len_q, len_d;
  logic            loop_q, loop_d;
  logic [AW:0]     sent_q, sent_d;
  logic [15:0]     pass_q, pass_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            done_q, done_d;
  logic            active_q;
  logic [7:0]      rd_q;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // tx_req must appear in the SEND cycle itself and be suppressed by a same-cycle
  // abort or busy, so it is decoded from the registered state rather than registered.
  assign tx_req = (state_q == StSend) && !tx_busy && !abort;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    loop_d  = loop_q;
    sent_d  = sent_q;
    pass_d  = pass_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_d  = (length > DepthLen) ? DepthLen : length;
            loop_d = loop_en;
            sent_d = '0;
            pass_d = '0;
            addr_d = '0;
            if (len_d == '0) done_d = 1'b1;
            else             state_d = StFetch;
          end
        end
        StFetch: state_d = StSend;
        StSend: begin
          if (!tx_busy) begin
            sent_d  = sent_q + 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = StHold;
          end
        end
        // UART busy is not yet valid in the cycle right after tx_req.
        StHold: state_d = StWaitb;
        StWaitb: begin
          if (!tx_busy) begin
            gap_d = '0;
            if (addr_q == len_q) begin
              if (pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
              if (loop_q) begin
                addr_d  = '0;
                sent_d  = '0;
                state_d = BeatNext;
              end else begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end else begin
              state_d = BeatNext;
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) state_d = StFetch;
          else                  gap_d   = gap_q + 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      sent_q   <= '0;
      pass_q   <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      rd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
      sent_q   <= sent_d;
      pass_q   <= pass_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      active_q <= (state_d != StIdle);
      // Read-first: a same-cycle write to this address is seen on the next fetch.
      if (state_q == StFetch) rd_q <= mem[addr_q[AW-1:0]];
    end
  end

  assign tx_byte    = rd_q;
  assign active     = active_q;
  assign done       = done_q;
  assign sent_count = sent_q;
  assign pass_count = pass_q;

`ifdef UART_PLAYER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       start_fire;

  assign start_fire = (state_q == StIdle) && start && !abort;

  always_comb begin
    sum_d = sum_q;
    if (start_fire)  sum_d = 8'h00;
    else if (tx_req) sum_d = sum_q + rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

  assign checksum = sum_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_uart_vector_player.sv
// Bench for uart_vector_player: a gapless instance with the default depth and a
// small instance with a 5-cycle gap. Expected bytes go into per-instance queues at
// stimulus time; negedge monitors pop and compare on every tx_req.
module tb_uart_vector_player;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned AW     = 11;
  localparam int unsigned GDEPTH = 16;
  localparam int unsigned GAW    = 4;
  localparam int unsigned GAP    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = 8'h00;
  logic [AW:0]   length = '0;
  logic          loop_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0]    tx_byte;
  logic          tx_req, tx_busy, active, done;
  logic [AW:0]   sent_count;
  logic [15:0]   pass_count;
  logic [7:0]    checksum;

  logic [GAW:0]  g_length = '0;
  logic          g_start = 1'b0, g_loop = 1'b0, g_abort = 1'b0;
  logic [7:0]    g_tx_byte, g_checksum;
  logic          g_tx_req, g_tx_busy, g_active, g_done;
  logic [GAW:0]  g_sent;
  logic [15:0]   g_pass;

  uart_vector_player dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .length(length), .loop_en(loop_en), .start(start), .abort(abort),
    .tx_byte(tx_byte), .tx_req(tx_req), .tx_busy(tx_busy), .active(active), .done(done),
    .sent_count(sent_count), .pass_count(pass_count), .checksum(checksum)
  );

  uart_vector_player #(.DEPTH(GDEPTH), .GAP_CYCLES(GAP)) dut_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr[GAW-1:0]), .wr_data(wr_data),
    .length(g_length), .loop_en(g_loop), .start(g_start), .abort(g_abort),
    .tx_byte(g_tx_byte), .tx_req(g_tx_req), .tx_busy(g_tx_busy), .active(g_active),
    .done(g_done), .sent_count(g_sent), .pass_count(g_pass), .checksum(g_checksum)
  );

  // UART models: busy for busy_len cycles starting the cycle after tx_req.
  int unsigned busy_len = 10;
  int unsigned busy_cnt = 0, g_busy_cnt = 0;
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_req) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (g_tx_req) g_busy_cnt <= busy_len;
    else if (g_busy_cnt != 0) g_busy_cnt <= g_busy_cnt - 1;
  end
  assign tx_busy   = (busy_cnt != 0);
  assign g_tx_busy = (g_busy_cnt != 0);

  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] g_q[$];
  int req_cnt = 0, done_cnt = 0, first_req_cyc = -1;
  bit first_req_pending = 1'b0;
  int g_req_cnt = 0, g_done_cnt = 0, g_fall_cyc = -1, g_spacing = -1;
  logic prev_req = 1'b0, g_busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Main instance monitor.
  initial forever begin
    @(negedge clk);
    if (done) done_cnt++;
    if (tx_req) begin
      req_cnt++;
      if (first_req_pending) begin
        first_req_cyc = cyc;
        first_req_pending = 1'b0;
      end
      check("req_while_busy", 32'(tx_busy), 32'd0);
      check("req_back_to_back", 32'(prev_req), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%0h required=none", tx_byte);
      end else begin
        check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
    end
    prev_req = tx_req;
  end

  // Gap instance monitor; records the cycle busy is first seen low after a byte.
  initial forever begin
    @(negedge clk);
    if (g_done) g_done_cnt++;
    if (g_busy_prev && !g_tx_busy) g_fall_cyc = cyc;
    g_busy_prev = g_tx_busy;
    if (g_tx_req) begin
      g_req_cnt++;
      if (g_req_cnt == 2) g_spacing = cyc - g_fall_cyc;
      if (g_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gap_unexpected_req actual=%0h required=none", g_tx_byte);
      end else begin
        check("gap_tx_byte", 32'(g_tx_byte), 32'(g_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Pulses start for one cycle; returns the cycle index in which start was high.
  task automatic do_start(input int len, input logic lp, output int t);
    length = (AW + 1)'(len);
    loop_en = lp;
    start = 1'b1;
    t = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound, input string name);
    int n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_reqs(input int target, input int bound, input string name);
    int n = 0;
    while (req_cnt < target && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(req_cnt >= target), 32'd1);
  endtask

  initial begin
    int t, r0, d0, gr0, gd0;
    logic [7:0] sum;

    tick();
    tick();
    // Reset state (reset still asserted).
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sent", 32'(sent_count), 32'd0);
    check("rst_pass", 32'(pass_count), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    reset = 1'b0;
    tick();

    // Three bytes, no gap, UART busy 10 cycles.
    write(0, 8'hA5);
    write(1, 8'h00);
    write(2, 8'hFF);
    busy_len = 10;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    r0 = req_cnt;
    d0 = done_cnt;
    first_req_pending = 1'b1;
    do_start(3, 1'b0, t);
    check("t1_active_T+1", 32'(active), 32'd1);
    wait_done(d0, 200, "t1_done_seen");
    check("t1_active_after_done", 32'(active), 32'd0);
    repeat (5) tick();
    check("t1_first_req_T+2", 32'(first_req_cyc), 32'(t + 2));
    check("t1_req_count", 32'(req_cnt - r0), 32'd3);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);
    check("t1_sent", 32'(sent_count), 32'd3);
    check("t1_pass", 32'(pass_count), 32'd1);
`ifdef UART_PLAYER_CHECKSUM_EN
    check("t1_checksum", 32'(checksum), 32'hA4);
`else
    check("t1_checksum", 32'(checksum), 32'h00);
`endif

    // Gap instance: length 2, 5 gap cycles. Busy is first seen low in cycle W; WAITB
    // exit, 5 gap cycles, FETCH and SEND span G+3 cycles, so tx_req lands at W+G+2.
    g_q.push_back(8'hA5);
    g_q.push_back(8'h00);
    gr0 = g_req_cnt;
    gd0 = g_done_cnt;
    g_length = 5'd2;
    g_start = 1'b1;
    tick();
    g_start = 1'b0;
    for (int n = 0; n < 200 && g_done_cnt == gd0; n++) tick();
    check("gap_done_seen", 32'(g_done_cnt - gd0), 32'd1);
    check("gap_req_count", 32'(g_req_cnt - gr0), 32'd2);
    check("gap_req_after_busy_low", 32'(g_spacing), 32'(GAP + 2));
    check("gap_sent", 32'(g_sent), 32'd2);
    check("gap_pass", 32'(g_pass), 32'd1);
    check("gap_active", 32'(g_active), 32'd0);
`ifdef UART_PLAYER_CHECKSUM_EN
    check("gap_checksum", 32'(g_checksum), 32'hA5);
`else
    check("gap_checksum", 32'(g_checksum), 32'h00);
`endif

    // Length 0: done at T+1, no request.
    r0 = req_cnt;
    d0 = done_cnt;
    do_start(0, 1'b0, t);
    check("len0_done_T+1", 32'(done), 32'd1);
    tick();
    check("len0_done_single", 32'(done), 32'd0);
    repeat (4) tick();
    check("len0_no_req", 32'(req_cnt - r0), 32'd0);

    // Start and abort together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_active", 32'(active), 32'd0);
    repeat (4) tick();
    check("start_abort_no_req", 32'(req_cnt - r0), 32'd0);

    // Loop, length 2, abort after 5 requests.
    write(0, 8'h11);
    write(1, 8'h22);
    busy_len = 3;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h11);
    r0 = req_cnt;
    d0 = done_cnt;
    do_start(2, 1'b1, t);
    wait_reqs(r0 + 5, 200, "loop_reqs_seen");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("loop_active_after_abort", 32'(active), 32'd0);
    check("loop_pass", 32'(pass_count), 32'd2);
    check("loop_sent", 32'(sent_count), 32'd1);
    repeat (10) tick();
    check("loop_req_count", 32'(req_cnt - r0), 32'd5);
    check("loop_no_done", 32'(done_cnt - d0), 32'd0);
    check("loop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Write to address 1 in the cycle it is being fetched: old byte this pass.
    write(0, 8'h5A);
    write(1, 8'hC3);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h7E);
    r0 = req_cnt;
    do_start(2, 1'b1, t);
    wait_reqs(r0 + 1, 100, "wff_first_req");
    // Now in cycle R+1; FETCH of address 1 is cycle R+busy_len+2 = R+5.
    repeat (4) tick();
    write(1, 8'h7E);
    wait_reqs(r0 + 4, 200, "wff_reqs_seen");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (8) tick();
    check("wff_req_count", 32'(req_cnt - r0), 32'd4);
    check("wff_pass", 32'(pass_count), 32'd1);
    check("wff_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while in WAITB, then replay from address 0.
    busy_len = 10;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'hFF);
    r0 = req_cnt;
    do_start(3, 1'b0, t);
    wait_reqs(r0 + 1, 100, "rstw_first_req");
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rstw_tx_req", 32'(tx_req), 32'd0);
    check("rstw_tx_byte", 32'(tx_byte), 32'd0);
    check("rstw_active", 32'(active), 32'd0);
    check("rstw_done", 32'(done), 32'd0);
    check("rstw_sent", 32'(sent_count), 32'd0);
    check("rstw_pass", 32'(pass_count), 32'd0);
    check("rstw_checksum", 32'(checksum), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h5A);
    r0 = req_cnt;
    d0 = done_cnt;
    do_start(1, 1'b0, t);
    wait_done(d0, 200, "rstw_replay_done");
    check("rstw_replay_reqs", 32'(req_cnt - r0), 32'd1);
    check("rstw_replay_pass", 32'(pass_count), 32'd1);
    check("rstw_queue_empty", 32'(exp_q.size()), 32'd0);

    // Length beyond DEPTH clamps to DEPTH.
    busy_len = 1;
    sum = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      write(i, 8'(i) ^ 8'h3C);
      exp_q.push_back(8'(i) ^ 8'h3C);
      sum = sum + (8'(i) ^ 8'h3C);
    end
    r0 = req_cnt;
    d0 = done_cnt;
    do_start(DEPTH + 5, 1'b0, t);
    wait_done(d0, 20000, "big_done_seen");
    check("big_req_count", 32'(req_cnt - r0), 32'(DEPTH));
    check("big_sent", 32'(sent_count), 32'(DEPTH));
    check("big_pass", 32'(pass_count), 32'd1);
`ifdef UART_PLAYER_CHECKSUM_EN
    check("big_checksum", 32'(checksum), 32'(sum));
`else
    check("big_checksum", 32'(checksum), 32'h00);
`endif
    check("big_queue_empty", 32'(exp_q.size()), 32'd0);
    check("gap_queue_empty", 32'(g_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
